// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the divided-clock period meter.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } meter_state_e;

    localparam logic [2:0] SEL_DIV2  = 3'd0;
    localparam logic [2:0] SEL_DIV4  = 3'd1;
    localparam logic [2:0] SEL_DIV8  = 3'd2;
    localparam logic [2:0] SEL_DIV16 = 3'd3;
    localparam logic [2:0] SEL_DIV32 = 3'd4;
    localparam logic [2:0] SEL_MAX   = 3'd4;

    // Nominal period, in clk cycles, of divider output 'sel'.
    function automatic int expected_period(input logic [2:0] sel);
        return 2 << sel;
    endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Request/result bundle between a controller and the period meter.
interface clk_period_meter_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       sel;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic             timeout;

    modport master (
        output sel, start,
        input  busy, done, period, high_cnt, timeout
    );

    modport slave (
        input  sel, start,
        output busy, done, period, high_cnt, timeout
    );
endinterface

// File: rtl/clk_period_meter_rise_detect.sv
// Rising-edge detector with a preloadable history bit, so a fresh selection
// never produces an edge in the cycle it is chosen.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic cur,
    input  logic load,
    input  logic load_val,
    output logic rise
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = load ? load_val : cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = cur & ~prev_q;
endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of one divided clock, in master clk cycles,
// between two consecutive sampled rising edges.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          div_in,
    clk_period_meter_if.slave   bus
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    meter_state_e     state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic [7:0]       div_ext;
    logic             sel_ok;
    logic             cur;
    logic             rise;
    logic             load;
    logic [CNT_W-1:0] cur_w;

    // Padding to 8 bits keeps any 3-bit index in range; invalid selects read 0.
    assign div_ext = {3'b000, div_in};
    assign sel_ok  = (bus.sel <= SEL_MAX);
    assign cur     = div_ext[sel_q];
    assign cur_w   = {{(CNT_W-1){1'b0}}, cur};
    assign load    = (state_q == IDLE) && bus.start && sel_ok;

    rise_detect u_rise (
        .clk      (clk),
        .rst_n    (rst_n),
        .cur      (cur),
        .load     (load),
        .load_val (div_ext[bus.sel]),
        .rise     (rise)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    period_d = '0;
                    high_d   = '0;
                    if (sel_ok) begin
                        sel_d     = bus.sel;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        state_d   = ARM;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            ARM: begin
                if (rise) begin
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    acc_d   = cur_w;
                    state_d = MEASURE;
                end else if (cnt_q == TMO) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                // A rise in the same cycle as the limit still yields a result.
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = acc_q;
                    state_d  = DONE;
                end else if (cnt_q == TMO) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = acc_q + cur_w;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ARM) || (state_d == MEASURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            period_q  <= period_d;
            high_q    <= high_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.period   = period_q;
    assign bus.high_cnt = high_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter driven by a behavioural divider.
module tb_clk_period_meter;
    import clk_meter_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] div_cnt = '0;
    logic       div_run = 1'b1;

    always #5 clk = ~clk;

    // Divider model: bit i of a free-running counter has period 2^(i+1), half high.
    always @(posedge clk) begin
        if (!div_run) div_cnt <= '0;
        else          div_cnt <= div_cnt + 5'd1;
    end

    clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_in (div_cnt),
        .bus    (bus)
    );

    typedef struct {
        int period;
        int high;
        int tmo;
        int lat_min;
        int lat_max;
        int acc_cyc;
        bit no_busy;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    bit   have_last = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   done_expected = 0;
    int   cyc = 0;
    bit   busy_seen = 1'b0;
    bit   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected_range=[%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_seen = 1'b1;
            if (prev_done) check("done_one_cycle", bus.done, 0);
            prev_done = bus.done;
            if (bus.done) begin
                exp_t e;
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    check("period", bus.period, e.period);
                    check("high_cnt", bus.high_cnt, e.high);
                    check("timeout", bus.timeout, e.tmo);
                    check("busy_at_done", bus.busy, 0);
                    check_range("latency", cyc - e.acc_cyc + 1, e.lat_min, e.lat_max);
                    if (e.no_busy) check("busy_never", busy_seen, 0);
                    $display("txn period=%0d high=%0d timeout=%0d latency=%0d",
                             bus.period, bus.high_cnt, bus.timeout, cyc - e.acc_cyc + 1);
                    last = e;
                    have_last = 1'b1;
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("wait_done_budget", 0, 1);
            sb.delete();
        end
    endtask

    task automatic do_meas(input logic [2:0] s, input bit extra);
        exp_t e;
        int   p;
        @(negedge clk);
        if (have_last) begin
            check("hold_period", bus.period, last.period);
            check("hold_high", bus.high_cnt, last.high);
            check("hold_timeout", bus.timeout, last.tmo);
        end
        busy_seen = 1'b0;
        e.acc_cyc = cyc + 1;
        e.no_busy = 1'b0;
        if (s > 3'd4) begin
            e.period = 0; e.high = 0; e.tmo = 1;
            e.lat_min = 1; e.lat_max = 1; e.no_busy = 1'b1;
        end else if (!div_run) begin
            e.period = 0; e.high = 0; e.tmo = 1;
            e.lat_min = TIMEOUT + 2; e.lat_max = TIMEOUT + 2;
        end else begin
            p = expected_period(s);
            e.period = p; e.high = p / 2; e.tmo = 0;
            e.lat_min = p + 2; e.lat_max = 2 * p + 1;
        end
        sb.push_back(e);
        done_expected++;
        bus.sel   = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (extra) begin
            repeat (2) @(negedge clk);
            bus.sel   = 3'(s + 3'd1 + 3'($urandom_range(0, 5)));
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        bus.sel   = '0;
        bus.start = 1'b0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_period", bus.period, 0);
        check("rst_high", bus.high_cnt, 0);
        check("rst_timeout", bus.timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_meas(SEL_DIV2, 1'b0);
        do_meas(SEL_DIV8, 1'b0);
        do_meas(SEL_DIV32, 1'b0);
        do_meas(3'd6, 1'b0);
        do_meas(SEL_DIV8, 1'b1);

        // Divider held in reset: static zero input must time out.
        div_run = 1'b0;
        repeat (2) @(negedge clk);
        do_meas(SEL_DIV4, 1'b0);
        div_run = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            do_meas(s, (s <= SEL_MAX) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        // Asynchronous reset in the middle of a div32 measurement.
        begin
            int  n = 0;
            bit  pv;
            int  seen_before;
            @(negedge clk);
            bus.sel   = SEL_DIV32;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            pv = div_cnt[4];
            while (!(div_cnt[4] && !pv) && n < 100) begin
                pv = div_cnt[4];
                @(negedge clk);
                n++;
            end
            repeat (5) @(negedge clk);
            check("busy_before_reset", bus.busy, 1);
            seen_before = done_seen;
            #2 rst_n = 1'b0;
            #1;
            check("arst_busy", bus.busy, 0);
            check("arst_done", bus.done, 0);
            check("arst_period", bus.period, 0);
            check("arst_high", bus.high_cnt, 0);
            check("arst_timeout", bus.timeout, 0);
            @(negedge clk);
            rst_n = 1'b1;
            have_last = 1'b0;
            repeat (40) @(negedge clk);
            check("no_done_after_reset", done_seen, seen_before);
        end

        do_meas(SEL_DIV16, 1'b0);
        do_meas(SEL_DIV2, 1'b1);

        repeat (5) @(negedge clk);
        check("done_count", done_seen, done_expected);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
